ins_log_write_scheduler: RTL and testbench
==========================================

// Module: ins_log_write_scheduler
// PURPOSE
//  Schedules all writes into the graphic instruction memory of the instruction display path.
//  - Detects each change of the fetched instruction word and queues it in a small FIFO.
//  - Drains queued words into consecutive memory slots, one per cycle, only during VGA blanking,
//    so the character renderer never reads a slot while it is being written.
//  - Runs a full-memory clear sequence after reset and on request.
// PARAMETERS
//  DEPTH   4    FIFO entries (power of 2, >=2)
//  ADDR_W  6    memory address width; 2**ADDR_W slots
//  H_VIS   640  visible pixels per line; SYS_X >= H_VIS is blanking
//  V_VIS   480  visible lines; SYS_Y >= V_VIS is blanking
// PORTS
//  CLK       in   1       system clock; everything is on its rising edge
//  RST       in   1       synchronous, active-high reset
//  SYS_X     in   10      current VGA pixel column
//  SYS_Y     in   10      current VGA pixel row
//  INS       in   32      currently fetched instruction word
//  CLR       in   1       one-cycle request to clear the log
//  MEM_WE    out  1       memory write enable (registered)
//  MEM_ADDR  out  ADDR_W  memory write address (registered)
//  MEM_DATA  out  32      memory write data (registered)
//  BUSY      out  1       1 while in state CLEAR
//  OVF       out  1       sticky FIFO overflow flag
//  LEVEL     out  clog2(DEPTH)+1  FIFO occupancy
// BEHAVIOUR
//  Reset (RST=1 at an edge; takes effect whenever asserted, including mid-clear or mid-drain):
//   - state=CLEAR, clr_cnt=0, wr_ptr=0, FIFO emptied, last_ins=0.
//   - MEM_WE=0, MEM_ADDR=0, MEM_DATA=0, OVF=0, LEVEL=0, BUSY=1.
//  blank = (SYS_X>=H_VIS) | (SYS_Y>=V_VIS), taken combinationally from the current inputs.
//  Change detection:
//   - At each edge, last_ins<=INS.
//   - If INS!=last_ins, INS is pushed that edge. One push per change; a held value is not re-pushed.
//   - INS=0 right after reset is not logged.
//   - Pushes are accepted in every state, including CLEAR.
//  FIFO:
//   - Push while full (and no pop that edge): word dropped, OVF<=1. OVF clears only on RST or an accepted CLR.
//   - Push and pop at the same edge: both happen, LEVEL unchanged. This holds even when full; no overflow.
//  FSM states:
//   - CLEAR: on each edge with blank=1: MEM_WE<=1, MEM_ADDR<=clr_cnt, MEM_DATA<=0, clr_cnt++.
//     On the edge that writes slot 2**ADDR_W-1: go to IDLE, wr_ptr<=0.
//     Edges with blank=0: MEM_WE<=0, clr_cnt holds.
//   - IDLE: on an edge with blank=1 and LEVEL!=0: MEM_WE<=1, MEM_ADDR<=wr_ptr, MEM_DATA<=FIFO head,
//     pop, wr_ptr<=wr_ptr+1. Otherwise MEM_WE<=0.
//     wr_ptr wraps from 2**ADDR_W-1 to 0 with no flag; the oldest entries are overwritten.
//   - CLR=1 in IDLE: go to CLEAR, clr_cnt<=0, OVF<=0. FIFO contents are kept and drain after the clear.
//     CLR has priority over a pop at that edge; no pop occurs.
//   - CLR=1 in CLEAR: ignored.
//  Latency:
//   - A change on INS with an empty FIFO in IDLE during blanking appears on MEM_* 2 edges later
//     (push, then pop and register).
//   - Writes are issued only from edges that sampled blank=1. The MEM_WE pulse is therefore visible
//     in the cycle after that sample.
//  BUSY is a registered decode of state==CLEAR.
// TESTING
//  1. RST 1 cycle, SYS_Y=500 constant -> BUSY=1; MEM_WE=1 for 64 cycles with ADDR 0..63, DATA=0;
//     then BUSY=0, MEM_WE=0.
//  2. After clear, SYS_Y=500: INS 0->0xE3A01005 -> 2 edges later MEM_WE=1, ADDR=0, DATA=0xE3A01005,
//     for exactly one cycle.
//  3. SYS_X=100, SYS_Y=100 (visible): 3 distinct INS changes -> MEM_WE stays 0, LEVEL=3.
//     Then SYS_Y=490 -> 3 consecutive writes at ADDR 0,1,2 in push order; LEVEL returns to 0.
//  4. Visible area: 5 changes with DEPTH=4 -> LEVEL=4, OVF=1, 5th word never written.
//     Then CLR=1 -> OVF=0, BUSY=1.
//  5. Preload wr_ptr=63 via 63 logged words, log 2 more -> writes at ADDR 63 then 0.
//  6. RST pulse during CLEAR at clr_cnt=20 -> next cycle outputs at reset values;
//     a fresh clear runs from ADDR 0.

Source files
------------

// File: rtl/ins_log_write_scheduler.sv
// ins_log_write_scheduler
//   Schedules every write into the graphic instruction memory of the
//   instruction display path. Each change of the fetched instruction word is
//   queued in a small FIFO. Queued words drain into consecutive memory slots,
//   one per cycle, and only during VGA blanking, so the character renderer
//   never reads a slot while it is being written. A full-memory clear runs
//   after reset and on request.
//
// Ports
//   CLK       system clock, rising edge
//   RST       synchronous active-high reset
//   SYS_X     current VGA pixel column
//   SYS_Y     current VGA pixel row
//   INS       currently fetched instruction word
//   CLR       one-cycle request to clear the log (ignored while clearing)
//   MEM_WE    registered memory write enable
//   MEM_ADDR  registered memory write address
//   MEM_DATA  registered memory write data
//   BUSY      high while the clear sequence runs
//   OVF       sticky FIFO overflow flag
//   LEVEL     FIFO occupancy
module ins_log_write_scheduler #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 6,
  parameter int H_VIS  = 640,
  parameter int V_VIS  = 480
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [9:0]                 SYS_X,
  input  logic [9:0]                 SYS_Y,
  input  logic [31:0]                INS,
  input  logic                       CLR,
  output logic                       MEM_WE,
  output logic [ADDR_W-1:0]          MEM_ADDR,
  output logic [31:0]                MEM_DATA,
  output logic                       BUSY,
  output logic                       OVF,
  output logic [$clog2(DEPTH):0]     LEVEL
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [9:0]        H_VIS_L   = 10'(H_VIS);
  localparam logic [9:0]        V_VIS_L   = 10'(V_VIS);
  localparam logic [ADDR_W-1:0] LAST_SLOT = '1;
  localparam logic [LVL_W-1:0]  FULL_LVL  = LVL_W'(DEPTH);

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [31:0]         last_ins_q;
  logic [31:0]         fifo_q [DEPTH];
  logic [PTR_W-1:0]    fwp_q, frp_q;
  logic [LVL_W-1:0]    level_q, level_d;
  logic                ovf_q;
  logic                busy_q;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_data_q, mem_data_d;

  logic blank, push, full, empty, clr_go, pop, push_ok, ovf_set;

  assign blank  = (SYS_X >= H_VIS_L) || (SYS_Y >= V_VIS_L);
  assign push   = (INS != last_ins_q);
  assign full   = (level_q == FULL_LVL);
  assign empty  = (level_q == '0);
  assign clr_go = CLR && (state_q == S_IDLE);
  // A clear request wins over a drain at the same edge.
  assign pop    = (state_q == S_IDLE) && blank && !empty && !clr_go;
  // A full FIFO still accepts a word when the head leaves at the same edge.
  assign push_ok = push && (!full || pop);
  assign ovf_set = push && full && !pop;

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_CLEAR;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_CLEAR: if (blank && (clr_cnt_q == LAST_SLOT)) state_d = S_IDLE;
      S_IDLE:  if (CLR) state_d = S_CLEAR;
      default: state_d = S_CLEAR;
    endcase
  end

  // Output / datapath next-state logic
  always_comb begin
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    clr_cnt_d  = clr_cnt_q;
    wr_ptr_d   = wr_ptr_q;
    case (state_q)
      S_CLEAR: begin
        if (blank) begin
          mem_we_d   = 1'b1;
          mem_addr_d = clr_cnt_q;
          mem_data_d = '0;
          clr_cnt_d  = clr_cnt_q + 1'b1;
          if (clr_cnt_q == LAST_SLOT) wr_ptr_d = '0;
        end
      end
      S_IDLE: begin
        if (clr_go) begin
          clr_cnt_d = '0;
        end else if (pop) begin
          mem_we_d   = 1'b1;
          mem_addr_d = wr_ptr_q;
          mem_data_d = fifo_q[frp_q];
          // Wraps silently; oldest slots are overwritten.
          wr_ptr_d   = wr_ptr_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    level_d = level_q;
    case ({push_ok, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Control and output registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      clr_cnt_q  <= '0;
      wr_ptr_q   <= '0;
      last_ins_q <= '0;
      fwp_q      <= '0;
      frp_q      <= '0;
      level_q    <= '0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b1;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end else begin
      clr_cnt_q  <= clr_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      last_ins_q <= INS;
      level_q    <= level_d;
      busy_q     <= (state_d == S_CLEAR);
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      if (push_ok) fwp_q <= fwp_q + 1'b1;
      if (pop)     frp_q <= frp_q + 1'b1;
      // A dropped word at the clear edge still leaves the flag set.
      if (ovf_set)     ovf_q <= 1'b1;
      else if (clr_go) ovf_q <= 1'b0;
    end
  end

  // FIFO storage carries data only and needs no reset
  always_ff @(posedge CLK) begin
    if (push_ok) fifo_q[fwp_q] <= INS;
  end

  assign MEM_WE   = mem_we_q;
  assign MEM_ADDR = mem_addr_q;
  assign MEM_DATA = mem_data_q;
  assign BUSY     = busy_q;
  assign OVF      = ovf_q;
  assign LEVEL    = level_q;

endmodule

// File: tb/tb_ins_log_write_scheduler.sv
module tb_ins_log_write_scheduler;

  logic        CLK = 1'b0;
  logic        RST;
  logic [9:0]  SYS_X, SYS_Y;
  logic [31:0] INS;
  logic        CLR;
  logic        MEM_WE;
  logic [5:0]  MEM_ADDR;
  logic [31:0] MEM_DATA;
  logic        BUSY, OVF;
  logic [2:0]  LEVEL;

  int checks = 0;
  int errors = 0;

  ins_log_write_scheduler #(.DEPTH(4), .ADDR_W(6), .H_VIS(640), .V_VIS(480)) dut (
    .CLK(CLK), .RST(RST), .SYS_X(SYS_X), .SYS_Y(SYS_Y), .INS(INS), .CLR(CLR),
    .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA),
    .BUSY(BUSY), .OVF(OVF), .LEVEL(LEVEL)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Runs a clear already in progress to completion during blanking and
  // checks that slots 0..63 are each written with zero.
  task automatic wait_clear();
    int n;
    n = 0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      n = k;
      chk("clr_we", 32'(MEM_WE), 32'd1);
      chk("clr_addr", 32'(MEM_ADDR), 32'(k - 1));
      chk("clr_data", MEM_DATA, 32'd0);
      if (BUSY == 1'b0) break;
      if (k == 100) chk("clr_timeout", 32'(BUSY), 32'd0);
    end
    chk("clr_len", 32'(n), 32'd64);
  endtask

  function automatic logic [31:0] t5_word(input int j);
    if (j < 63)       return 32'(j + 1);
    else if (j == 63) return 32'hAAAA_0001;
    else              return 32'hAAAA_0002;
  endfunction

  initial begin
    RST = 1'b1; SYS_X = 10'd0; SYS_Y = 10'd500; INS = 32'd0; CLR = 1'b0;

    // Test 1: reset then full clear
    tick();
    chk("rst_busy", 32'(BUSY), 32'd1);
    chk("rst_we", 32'(MEM_WE), 32'd0);
    chk("rst_addr", 32'(MEM_ADDR), 32'd0);
    chk("rst_data", MEM_DATA, 32'd0);
    chk("rst_ovf", 32'(OVF), 32'd0);
    chk("rst_level", 32'(LEVEL), 32'd0);
    RST = 1'b0;
    wait_clear();
    tick();
    chk("t1_we_off", 32'(MEM_WE), 32'd0);
    chk("t1_busy_off", 32'(BUSY), 32'd0);

    // Test 2: single change, two-edge latency, one-cycle pulse
    INS = 32'hE3A0_1005;
    tick();
    chk("t2_we_e1", 32'(MEM_WE), 32'd0);
    chk("t2_lvl_e1", 32'(LEVEL), 32'd1);
    tick();
    chk("t2_we", 32'(MEM_WE), 32'd1);
    chk("t2_addr", 32'(MEM_ADDR), 32'd0);
    chk("t2_data", MEM_DATA, 32'hE3A0_1005);
    chk("t2_lvl", 32'(LEVEL), 32'd0);
    tick();
    chk("t2_we_off", 32'(MEM_WE), 32'd0);

    // Restart the log so the next burst lands at slot 0
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    chk("clr_busy", 32'(BUSY), 32'd1);
    chk("clr_we0", 32'(MEM_WE), 32'd0);
    wait_clear();

    // Test 3: changes while visible are held until blanking
    SYS_X = 10'd100; SYS_Y = 10'd100;
    INS = 32'h1111_0001; tick();
    INS = 32'h1111_0002; tick();
    INS = 32'h1111_0003; tick();
    chk("t3_we_vis", 32'(MEM_WE), 32'd0);
    chk("t3_lvl3", 32'(LEVEL), 32'd3);
    SYS_Y = 10'd490;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_we", 32'(MEM_WE), 32'd1);
      chk("t3_addr", 32'(MEM_ADDR), 32'(i));
      chk("t3_data", MEM_DATA, 32'h1111_0001 + 32'(i));
      chk("t3_lvl", 32'(LEVEL), 32'(2 - i));
    end
    tick();
    chk("t3_we_off", 32'(MEM_WE), 32'd0);

    // Test 4: overflow in visible area, then clear request
    SYS_Y = 10'd100;
    for (int i = 0; i < 4; i++) begin
      INS = 32'hD000_0001 + 32'(i);
      tick();
    end
    chk("t4_lvl_full", 32'(LEVEL), 32'd4);
    chk("t4_ovf0", 32'(OVF), 32'd0);
    INS = 32'hD000_0005;
    tick();
    chk("t4_lvl_ovf", 32'(LEVEL), 32'd4);
    chk("t4_ovf1", 32'(OVF), 32'd1);
    chk("t4_we_vis", 32'(MEM_WE), 32'd0);
    SYS_Y = 10'd500;
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    chk("t4_ovf_clr", 32'(OVF), 32'd0);
    chk("t4_busy", 32'(BUSY), 32'd1);
    chk("t4_lvl_kept", 32'(LEVEL), 32'd4);
    wait_clear();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t4_dr_we", 32'(MEM_WE), 32'd1);
      chk("t4_dr_addr", 32'(MEM_ADDR), 32'(i));
      chk("t4_dr_data", MEM_DATA, 32'hD000_0001 + 32'(i));
    end
    tick();
    chk("t4_no5th", 32'(MEM_WE), 32'd0);
    chk("t4_lvl0", 32'(LEVEL), 32'd0);

    // Test 5: write pointer wraps from 63 to 0
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    wait_clear();
    for (int j = 0; j <= 65; j++) begin
      if (j <= 64) INS = t5_word(j);
      tick();
      if (j >= 1) begin
        chk("t5_we", 32'(MEM_WE), 32'd1);
        chk("t5_addr", 32'(MEM_ADDR), 32'((j - 1) % 64));
        chk("t5_data", MEM_DATA, t5_word(j - 1));
      end
    end
    tick();
    chk("t5_we_off", 32'(MEM_WE), 32'd0);

    // Test 6: reset in the middle of a clear
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) CLR = 1'b1;
      if (i == 15) INS = 32'h1234_5678;
      tick();
      CLR = 1'b0;
      chk("t6_addr", 32'(MEM_ADDR), 32'(i));
      chk("t6_busy", 32'(BUSY), 32'd1);
    end
    chk("t6_push_clear", 32'(LEVEL), 32'd1);
    RST = 1'b1; INS = 32'd0;
    tick();
    RST = 1'b0;
    chk("t6_rst_busy", 32'(BUSY), 32'd1);
    chk("t6_rst_we", 32'(MEM_WE), 32'd0);
    chk("t6_rst_addr", 32'(MEM_ADDR), 32'd0);
    chk("t6_rst_data", MEM_DATA, 32'd0);
    chk("t6_rst_lvl", 32'(LEVEL), 32'd0);
    chk("t6_rst_ovf", 32'(OVF), 32'd0);
    wait_clear();
    tick();
    chk("t6_end_we", 32'(MEM_WE), 32'd0);
    chk("t6_end_lvl", 32'(LEVEL), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
